// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command sequencer: FSM states,
// command opcodes, heading codes and the bit position of each L move.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        V_ISSUE,
        V_WAIT,
        H_ISSUE,
        H_WAIT
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // Bit index of each L move within the one-hot move byte, named by (dx,dy).
    localparam int MV_R1_U2 = 0;
    localparam int MV_L1_U2 = 1;
    localparam int MV_L2_U1 = 2;
    localparam int MV_L2_D1 = 3;
    localparam int MV_L1_D2 = 4;
    localparam int MV_R1_D2 = 5;
    localparam int MV_R2_D1 = 6;
    localparam int MV_R2_U1 = 7;

    function automatic logic [15:0] make_cmd(input logic [3:0] opcode,
                                             input logic [7:0] heading,
                                             input logic [3:0] squares);
        return {opcode, heading, squares};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational decode of a one-hot L move into signed (dx, dy) steps,
// with a legality flag that is low unless exactly one bit is set.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]        move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy,
    output logic              legal
);

    assign legal = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

    // Offsets are only meaningful when legal is high.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        if (move[MV_R1_U2]) begin dx =  3'sd1; dy =  3'sd2; end
        if (move[MV_L1_U2]) begin dx = -3'sd1; dy =  3'sd2; end
        if (move[MV_L2_U1]) begin dx = -3'sd2; dy =  3'sd1; end
        if (move[MV_L2_D1]) begin dx = -3'sd2; dy = -3'sd1; end
        if (move[MV_L1_D2]) begin dx = -3'sd1; dy = -3'sd2; end
        if (move[MV_R1_D2]) begin dx =  3'sd1; dy = -3'sd2; end
        if (move[MV_R2_D1]) begin dx =  3'sd2; dy = -3'sd1; end
        if (move[MV_R2_U1]) begin dx =  3'sd2; dy =  3'sd1; end
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as movement commands: each L move becomes a
// vertical move followed by a horizontal move with fanfare; UART passes through when idle.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tour_go,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_err
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t            state_reg, state_next;
    logic [4:0]        mv_indx_reg, mv_indx_next;
    logic              tour_err_reg, tour_err_next;
    logic signed [2:0] dx, dy;
    logic              legal;
    logic [3:0]        abs_dx, abs_dy;
    logic              last_move;

    tour_move_decode u_decode (
        .move  (move),
        .dx    (dx),
        .dy    (dy),
        .legal (legal)
    );

    assign abs_dx    = {1'b0, (dx[2] ? -dx : dx)};
    assign abs_dy    = {1'b0, (dy[2] ? -dy : dy)};
    assign last_move = (mv_indx_reg == LAST_IDX);
    assign mv_indx   = mv_indx_reg;
    assign tour_err  = tour_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mv_indx_reg  <= 5'd0;
            tour_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mv_indx_reg  <= mv_indx_next;
            tour_err_reg <= tour_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mv_indx_next  = mv_indx_reg;
        tour_err_next = tour_err_reg;
        cmd           = 16'h0000;
        cmd_rdy       = 1'b0;
        resp          = RESP_BUSY;
        unique case (state_reg)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (tour_go) begin
                    mv_indx_next  = 5'd0;
                    tour_err_next = 1'b0;
                    state_next    = V_ISSUE;
                end
            end
            V_ISSUE: begin
                // A corrupt move aborts the tour before anything is commanded.
                if (!legal) begin
                    tour_err_next = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cmd     = make_cmd(OP_MOVE, (dy > 3'sd0) ? HEAD_N : HEAD_S, abs_dy);
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) state_next = V_WAIT;
                end
            end
            V_WAIT: begin
                if (send_resp) state_next = H_ISSUE;
            end
            H_ISSUE: begin
                cmd     = make_cmd(OP_FANFARE, (dx > 3'sd0) ? HEAD_E : HEAD_W, abs_dx);
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_next = H_WAIT;
            end
            H_WAIT: begin
                if (last_move) resp = RESP_DONE;
                if (send_resp) begin
                    if (last_move) begin
                        state_next = IDLE;
                    end else begin
                        mv_indx_next = mv_indx_reg + 5'd1;
                        state_next   = V_ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/tour_cmd_seq.md
TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, meaning the count of L moves in one tour (5x5 board).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tour_go  input  1  one-cycle pulse from the command processor: the computed tour is ready to execute.
REQ-005 SHALL have port move  input  8  one-hot L move read combinationally from the tour solver's move memory at mv_indx.
REQ-006 SHALL have port mv_indx  output  5  current move index.
REQ-007 SHALL have port cmd_UART  input  16  command from the UART wrapper.
REQ-008 SHALL have port cmd_rdy_UART  input  1  cmd_UART valid.
REQ-009 SHALL have port cmd  output  16  command to the command processor.
REQ-010 SHALL have port cmd_rdy  output  1  cmd valid.
REQ-011 SHALL have port clr_cmd_rdy  input  1  command processor accepted cmd.
REQ-012 SHALL have port send_resp  input  1  command processor finished the current command.
REQ-013 SHALL have port resp  output  8  response byte to the UART wrapper.
REQ-014 SHALL have port tour_err  output  1  sticky error: illegal move encoding.

Function
REQ-015 States SHALL be IDLE, V_ISSUE, V_WAIT, H_ISSUE, H_WAIT.
REQ-016 In IDLE, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and resp=8'hA5.
REQ-017 In any other state, cmd and cmd_rdy SHALL come from the sequencer only, and cmd_rdy_UART SHALL be ignored.
REQ-018 In IDLE, tour_go SHALL clear mv_indx to 0, clear tour_err and go to V_ISSUE.
REQ-019 tour_go outside IDLE SHALL be ignored.
REQ-020 Command format: [15:12] opcode (4'h2 move, 4'h3 move with fanfare), [11:4] heading, [3:0] squares.
REQ-021 Headings SHALL be: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-022 Move bit encoding (dx,dy): b0(+1,+2), b1(-1,+2), b2(-2,+1), b3(-2,-1), b4(-1,-2), b5(+1,-2), b6(+2,-1), b7(+2,+1).
REQ-023 In V_ISSUE, cmd SHALL be opcode 4'h2, heading N if dy>0 else S, squares |dy|, with cmd_rdy=1.
REQ-024 In H_ISSUE, cmd SHALL be opcode 4'h3, heading E if dx>0 else W, squares |dx|, with cmd_rdy=1.
REQ-025 In an ISSUE state, cmd_rdy SHALL hold until clr_cmd_rdy; then the block moves to the matching WAIT state next cycle, with cmd_rdy=0.
REQ-026 In V_WAIT, send_resp SHALL go to H_ISSUE.
REQ-027 In H_WAIT, send_resp SHALL go to IDLE if mv_indx==NUM_MOVES-1, else increment mv_indx and go to V_ISSUE.
REQ-028 During a tour, resp SHALL be 8'h5A, except 8'hA5 while in H_WAIT with mv_indx==NUM_MOVES-1.
REQ-029 send_resp in an ISSUE state and clr_cmd_rdy in a WAIT state SHALL be ignored.
REQ-030 clr_cmd_rdy and send_resp asserted together in an ISSUE state SHALL consume only clr_cmd_rdy.
REQ-031 If move is not one-hot on entry to V_ISSUE, the block SHALL set tour_err, issue no command and return to IDLE.
REQ-032 mv_indx SHALL never exceed NUM_MOVES-1; there is no wrap.

Reset
REQ-033 rst SHALL asynchronously force IDLE, mv_indx=0 and tour_err=0, including mid-tour, after which cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and resp=8'hA5.

Structure
REQ-034 Package tour_pkg SHALL hold the state enum, opcode constants, heading constants and move-bit indices.
REQ-035 Sub-module tour_move_decode (combinational: move -> dx, dy, legal) SHALL be instantiated once.

Verification
REQ-036 Idle passthrough: cmd_UART=16'h2004 with cmd_rdy_UART=1 -> cmd=16'h2004, cmd_rdy=1, resp=8'hA5.
REQ-037 Single move: tour_go with move=8'h01 -> cmd=16'h2002 (north 2); after clr and send_resp -> cmd=16'h3BF1 (east 1, fanfare).
REQ-038 Full tour: 24 moves with handshakes answered -> exactly 48 commands, resp=5A for the first 23 H_WAITs and A5 on the last, IDLE after, mv_indx=23.
REQ-039 Illegal move: move=8'h03 at V_ISSUE -> tour_err=1, no cmd_rdy, IDLE next cycle.
REQ-040 Reset mid-tour at mv_indx=10 in H_WAIT -> immediate IDLE, mv_indx=0, UART passthrough restored.
REQ-041 Simultaneous clr_cmd_rdy and send_resp in V_ISSUE -> V_WAIT only; a later send_resp -> H_ISSUE.
